// File: rtl/ad1_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ad1_sample_ctrl
// Description : Paced sample controller for the PmodAD1 SPI receiver. Issues
//               conversion requests at a programmable period, captures both
//               12-bit channels and presents results on a valid/ready stream
//               with sticky overflow and timeout flags.
//               Optional feature macro: AD1_SAMPLER_AVG_EN (averages
//               2^AVG_LOG2 samples per channel before producing a result).
// Revision    : 1.0 - initial release
// ============================================================================
module ad1_sample_ctrl #(
    parameter int PERIOD_W    = 16,
    parameter int TIMEOUT_CYC = 256,
    parameter int AVG_LOG2    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] sample_period,
    output logic                ad_start,
    input  logic                ad_done,
    input  logic [11:0]         ad_data1,
    input  logic [11:0]         ad_data2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [11:0]         out_ch1,
    output logic [11:0]         out_ch2,
    output logic                overflow,
    output logic                timeout_err,
    input  logic                clear_err
);

    localparam int c_TO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_BUSY = 3'd2,
        S_CAP  = 3'd3,
        S_WAIT = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_done_meta;
    logic                r_done_s;

    logic [PERIOD_W-1:0] r_period_cnt;
    logic [PERIOD_W-1:0] w_period_last;
    logic                w_period_hit;

    logic [c_TO_W-1:0]   r_to_cnt;
    logic                w_to_hit;
    logic                w_to_set;

    logic                w_capture;
    logic                w_enter_req;
    logic                w_enter_busy;

    logic                w_res_valid;
    logic [11:0]         w_res_ch1;
    logic [11:0]         w_res_ch2;
    logic                w_ovf_set;

    logic                r_out_valid;
    logic [11:0]         r_out_ch1;
    logic [11:0]         r_out_ch2;
    logic                r_overflow;
    logic                r_timeout_err;

    // Two-flop synchronizer for the receiver's done flag (idles high)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done_meta <= 1'b1;
            r_done_s    <= 1'b1;
        end else begin
            r_done_meta <= ad_done;
            r_done_s    <= r_done_meta;
        end
    end

    // A period of 0 behaves like 1: the WAIT comparison target is clamped at 0
    assign w_period_last = (sample_period == '0) ? '0 : (sample_period - 1'b1);
    assign w_period_hit  = (r_period_cnt >= w_period_last);
    assign w_to_hit      = (r_to_cnt == c_TO_W'(TIMEOUT_CYC - 1));

    assign w_enter_req   = (w_state_nxt == S_REQ)  && (r_state != S_REQ);
    assign w_enter_busy  = (w_state_nxt == S_BUSY) && (r_state != S_BUSY);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a late conversion re-enters REQ straight from CAP
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_to_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (w_to_hit) begin
                    w_to_set    = 1'b1;
                    w_state_nxt = S_WAIT;
                end else if (!r_done_s) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_to_hit) begin
                    w_to_set    = 1'b1;
                    w_state_nxt = S_WAIT;
                end else if (r_done_s) begin
                    w_state_nxt = S_CAP;
                end
            end
            S_CAP: begin
                w_capture = 1'b1;
                if (enable && w_period_hit) begin
                    w_state_nxt = S_REQ;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!enable) begin
                    w_state_nxt = S_IDLE;
                end else if (w_period_hit) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Decoded from state so it drops as soon as reset is asserted
    assign ad_start = (r_state == S_REQ);

    // Period counter: cycles since the last REQ entry, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period_cnt <= '0;
        end else if ((r_state == S_IDLE) || w_enter_req) begin
            r_period_cnt <= '0;
        end else if (r_period_cnt != '1) begin
            r_period_cnt <= r_period_cnt + 1'b1;
        end
    end

    // Handshake watchdog: restarts on REQ or BUSY entry, counts while in them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (w_enter_req || w_enter_busy) begin
            r_to_cnt <= '0;
        end else if ((r_state == S_REQ) || (r_state == S_BUSY)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

`ifdef AD1_SAMPLER_AVG_EN
    localparam int c_ACC_W = 12 + AVG_LOG2;

    logic [c_ACC_W-1:0]  r_acc1;
    logic [c_ACC_W-1:0]  r_acc2;
    logic [AVG_LOG2-1:0] r_avg_cnt;
    logic [c_ACC_W-1:0]  w_sum1;
    logic [c_ACC_W-1:0]  w_sum2;
    logic                w_avg_last;

    // Sum cannot overflow: 2^AVG_LOG2 samples of at most 4095 fit in c_ACC_W
    assign w_sum1     = r_acc1 + c_ACC_W'(ad_data1);
    assign w_sum2     = r_acc2 + c_ACC_W'(ad_data2);
    assign w_avg_last = (r_avg_cnt == '1);

    // Accumulators: a partial average is discarded whenever the FSM idles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc1    <= '0;
            r_acc2    <= '0;
            r_avg_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_acc1    <= '0;
            r_acc2    <= '0;
            r_avg_cnt <= '0;
        end else if (w_capture) begin
            if (w_avg_last) begin
                r_acc1    <= '0;
                r_acc2    <= '0;
                r_avg_cnt <= '0;
            end else begin
                r_acc1    <= w_sum1;
                r_acc2    <= w_sum2;
                r_avg_cnt <= r_avg_cnt + 1'b1;
            end
        end
    end

    assign w_res_valid = w_capture && w_avg_last;
    assign w_res_ch1   = w_sum1[c_ACC_W-1:AVG_LOG2];
    assign w_res_ch2   = w_sum2[c_ACC_W-1:AVG_LOG2];
`else
    // Plain build: every capture is a result; AVG_LOG2 has no effect here
    if (AVG_LOG2 >= 0) begin : g_passthru
        assign w_res_valid = w_capture;
        assign w_res_ch1   = ad_data1;
        assign w_res_ch2   = ad_data2;
    end
`endif

    // A result arriving while the held one is not being taken is dropped
    assign w_ovf_set = w_res_valid && r_out_valid && !out_ready;

    // Output register: holds until accepted; a same-cycle accept lets a new one in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_ch1   <= '0;
            r_out_ch2   <= '0;
        end else if (w_res_valid && (!r_out_valid || out_ready)) begin
            r_out_valid <= 1'b1;
            r_out_ch1   <= w_res_ch1;
            r_out_ch2   <= w_res_ch2;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky error flags; a set event outranks a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clear_err) begin
                r_overflow <= 1'b0;
            end
            if (w_to_set) begin
                r_timeout_err <= 1'b1;
            end else if (clear_err) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_ch1     = r_out_ch1;
    assign out_ch2     = r_out_ch2;
    assign overflow    = r_overflow;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_ad1_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ad1_sample_ctrl
// Description : Self-checking bench for ad1_sample_ctrl with a behavioural
//               PmodAD1 receiver and a sample-level result model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ad1_sample_ctrl;

    localparam int PERIOD_W    = 16;
    localparam int TIMEOUT_CYC = 256;
    localparam int AVG_LOG2    = 2;
`ifdef AD1_SAMPLER_AVG_EN
    localparam int AVG_N = 1 << AVG_LOG2;
`else
    localparam int AVG_N = 1;
`endif
    // 16 sclk periods at clk/4
    localparam int RX_CONV = 64;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                enable = 1'b0;
    logic [PERIOD_W-1:0] sample_period = '0;
    logic                ad_start;
    logic                ad_done = 1'b1;
    logic [11:0]         ad_data1 = '0;
    logic [11:0]         ad_data2 = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [11:0]         out_ch1;
    logic [11:0]         out_ch2;
    logic                overflow;
    logic                timeout_err;
    logic                clear_err = 1'b0;

    ad1_sample_ctrl #(
        .PERIOD_W    (PERIOD_W),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .AVG_LOG2    (AVG_LOG2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .sample_period (sample_period),
        .ad_start      (ad_start),
        .ad_done       (ad_done),
        .ad_data1      (ad_data1),
        .ad_data2      (ad_data2),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_ch1       (out_ch1),
        .out_ch2       (out_ch2),
        .overflow      (overflow),
        .timeout_err   (timeout_err),
        .clear_err     (clear_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model: samples -> expected results ----------
    logic [23:0] exp_q[$];
    int          exp_pushed = 0;
    int          acc1 = 0;
    int          acc2 = 0;
    int          acc_n = 0;

    function automatic void model_sample(input int d1, input int d2);
        acc1 += d1;
        acc2 += d2;
        acc_n++;
        if (acc_n == AVG_N) begin
            exp_q.push_back({12'(acc1 / AVG_N), 12'(acc2 / AVG_N)});
            exp_pushed++;
            acc1  = 0;
            acc2  = 0;
            acc_n = 0;
        end
    endfunction

    // ---------------- receiver model ----------------------------------------
    int          rx_state = 0;
    int          rx_cnt   = 0;
    int          rx_rises = 0;
    bit          rx_hang  = 1'b0;
    bit          rx_fixed = 1'b0;
    logic [11:0] fix1 = '0;
    logic [11:0] fix2 = '0;
    logic [11:0] src1_q[$];
    logic [11:0] src2_q[$];
    logic [11:0] d1;
    logic [11:0] d2;

    initial begin
        forever begin
            @(negedge clk);
            case (rx_state)
                0: begin
                    ad_done = 1'b1;
                    if (ad_start && !rx_hang) begin
                        ad_done  = 1'b0;
                        rx_cnt   = RX_CONV;
                        rx_state = 1;
                    end
                end
                1: begin
                    rx_cnt--;
                    if (rx_cnt == 0) begin
                        if (src1_q.size() > 0) begin
                            d1 = src1_q.pop_front();
                            d2 = src2_q.pop_front();
                        end else if (rx_fixed) begin
                            d1 = fix1;
                            d2 = fix2;
                        end else begin
                            d1 = 12'($urandom_range(0, 4095));
                            d2 = 12'($urandom_range(0, 4095));
                        end
                        ad_data1 = d1;
                        ad_data2 = d2;
                        model_sample(d1, d2);
                        rx_state = 2;
                    end
                end
                default: begin
                    if (!ad_start) begin
                        ad_done  = 1'b1;
                        rx_rises++;
                        rx_state = 0;
                    end
                end
            endcase
        end
    end

    // ---------------- scoreboard on accepted results ------------------------
    bit          sb_en   = 1'b1;
    int          sb_pops = 0;
    int          acc_cyc[$];
    logic [23:0] last_res = '0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst && sb_en && out_valid && out_ready) begin
                check("sb_expected_present", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check("sb_ch1", out_ch1, exp_q[0][23:12]);
                    check("sb_ch2", out_ch2, exp_q[0][11:0]);
                    void'(exp_q.pop_front());
                end
                sb_pops++;
                acc_cyc.push_back(cyc);
                last_res = {out_ch1, out_ch2};
            end
        end
    end

    // ad_start must stay up until the receiver has dropped done
    bit   mon_start  = 1'b1;
    logic prev_start = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_start && !rst && prev_start && !ad_start)
                check("start_held_until_done_low", ad_done, 0);
            prev_start = ad_start;
        end
    end

    task automatic wait_results(input int n, input int bound);
        int start = sb_pops;
        int i = 0;
        while (sb_pops < start + n && i < bound) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("results_arrived", sb_pops >= start + n, 1);
    endtask

    task automatic go_idle(input bit chk);
        int quiet = 0;
        enable = 1'b0;
        for (int i = 0; i < 8000 && quiet < 350; i++) begin
            @(posedge clk);
            #1;
            if (ad_start || rx_state != 0 || out_valid) quiet = 0;
            else quiet++;
        end
        check("idle_reached", quiet >= 350, 1);
        if (chk) check("results_drained", exp_q.size(), 0);
        exp_q.delete();
        src1_q.delete();
        src2_q.delete();
        acc1  = 0;
        acc2  = 0;
        acc_n = 0;
    endtask

    task automatic wait_cond_valid(input int bound, output bit ok);
        int i = 0;
        while (!out_valid && i < bound) begin
            @(posedge clk);
            #1;
            i++;
        end
        ok = out_valid;
    endtask

    // ---------------- directed sequence -------------------------------------
    initial begin
        bit          ok;
        int          n;
        int          rc;
        int          p0;
        int          e0;
        logic [23:0] first;
        logic        pv;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ad_start",    ad_start,    0);
        check("rst_out_valid",   out_valid,   0);
        check("rst_out_ch1",     out_ch1,     0);
        check("rst_out_ch2",     out_ch2,     0);
        check("rst_overflow",    overflow,    0);
        check("rst_timeout_err", timeout_err, 0);
        @(negedge clk);
        rst = 1'b0;

        // basic periodic sampling
        rx_fixed = 1'b1;
        fix1 = 12'hABC;
        fix2 = 12'h123;
        sample_period = 200;
        out_ready = 1'b1;
        acc_cyc.delete();
        enable = 1'b1;
        wait_results(4, 1200 * 4 * AVG_N);
        for (int i = 0; i < 3 && i + 1 < acc_cyc.size(); i++)
            check("t1_interval", acc_cyc[i + 1] - acc_cyc[i], 200 * AVG_N);
        check("t1_value", last_res, 24'hABC123);
        go_idle(1'b1);
        rx_fixed = 1'b0;

        // directed data including range extremes
        src1_q = '{12'd100, 12'd101, 12'd102, 12'd105};
        src2_q = '{12'd4095, 12'd0, 12'd2048, 12'd1};
        sample_period = 50;
        enable = 1'b1;
        wait_results(4 / AVG_N, 3000);
`ifdef AD1_SAMPLER_AVG_EN
        check("t2_avg_ch1", last_res[23:12], 102);
        check("t2_avg_ch2", last_res[11:0], 1536);
`else
        check("t2_last_ch1", last_res[23:12], 105);
`endif
        go_idle(1'b1);

        // randomized periods and data
        for (int b = 0; b < 3; b++) begin
            sample_period = PERIOD_W'($urandom_range(0, 300));
            enable = 1'b1;
            wait_results(3, 1500 * 3 * AVG_N);
            go_idle(1'b1);
        end

        // fast period: REQ re-entered right after CAP
        for (int p = 0; p < 2; p++) begin
            sample_period = PERIOD_W'(p);
            enable = 1'b1;
            for (int k = 0; k < 3; k++) begin
                pv = out_valid;
                n = 0;
                while (!(out_valid && !pv) && n < 1000 * AVG_N) begin
                    pv = out_valid;
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("t6_result_seen", out_valid, 1);
                check("t6_req_after_cap", ad_start, 1);
            end
            check("t6_no_overflow", overflow, 0);
            check("t6_no_timeout", timeout_err, 0);
            go_idle(1'b1);
        end

        // overflow: held result with ready low
        sb_en = 1'b0;
        out_ready = 1'b0;
        sample_period = 100;
        enable = 1'b1;
        wait_cond_valid(2000 * AVG_N, ok);
        check("t3_first_valid", ok, 1);
        first = (exp_q.size() > 0) ? exp_q[0] : 24'hxxxxxx;
        check("t3_first_data", {out_ch1, out_ch2}, first);
        n = 0;
        while (exp_q.size() < 2 && n < 2000 * AVG_N) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (10) @(negedge clk);
        check("t3_overflow_set", overflow, 1);
        check("t3_still_valid", out_valid, 1);
        check("t3_first_held", {out_ch1, out_ch2}, first);
        out_ready = 1'b1;
        go_idle(1'b0);
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("t3_overflow_cleared", overflow, 0);

        // accept and new result in the same cycle
        out_ready = 1'b0;
        enable = 1'b1;
        n = 0;
        while (exp_q.size() < 2 && n < 2000 * AVG_N) begin
            @(posedge clk);
            #1;
            n++;
        end
        rc = rx_rises;
        n = 0;
        while (rx_rises == rc && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("t3b_valid", out_valid, 1);
        first = (exp_q.size() > 1) ? exp_q[1] : 24'hxxxxxx;
        check("t3b_second_loaded", {out_ch1, out_ch2}, first);
        check("t3b_no_overflow", overflow, 0);
        out_ready = 1'b1;
        go_idle(1'b0);
        sb_en = 1'b1;

        // timeout: receiver never answers
        mon_start = 1'b0;
        rx_hang = 1'b1;
        sample_period = 200;
        enable = 1'b1;
        n = 0;
        while (!ad_start && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        n = 1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (!ad_start) break;
            n++;
        end
        check("t4_req_cycles", n, TIMEOUT_CYC);
        check("t4_timeout_set", timeout_err, 1);
        check("t4_start_low", ad_start, 0);
        check("t4_no_valid", out_valid, 0);
        enable = 1'b0;
        rx_hang = 1'b0;
        go_idle(1'b1);
        mon_start = 1'b1;
        check("t4_timeout_sticky", timeout_err, 1);
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("t4_timeout_cleared", timeout_err, 0);

        // enable dropped while the receiver is converting
        p0 = sb_pops;
        e0 = exp_pushed;
        sample_period = 200;
        enable = 1'b1;
        n = 0;
        while (rx_state != 1 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (5) @(negedge clk);
        enable = 1'b0;
        go_idle(1'b1);
        check("t5_results_delivered", sb_pops - p0, exp_pushed - e0);
        check("t5_start_low_idle", ad_start, 0);

        // reset mid-conversion with a result held
        sb_en = 1'b0;
        out_ready = 1'b0;
        sample_period = 50;
        enable = 1'b1;
        wait_cond_valid(1000 * AVG_N, ok);
        n = 0;
        while (rx_state != 1 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (5) @(negedge clk);
        check("t5_pre_reset_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("t5_rst_ad_start",    ad_start,    0);
        check("t5_rst_out_valid",   out_valid,   0);
        check("t5_rst_out_ch1",     out_ch1,     0);
        check("t5_rst_out_ch2",     out_ch2,     0);
        check("t5_rst_overflow",    overflow,    0);
        check("t5_rst_timeout_err", timeout_err, 0);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        go_idle(1'b0);
        sb_en = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
